usr_frame_serializer: RTL and testbench

Downstream stage for the 4-bit universal shift register's parallel output. Accepts one parallel word per valid/ready handshake and transmits it on a single line as a framed serial stream: start bit, data bits, optional parity bit, stop bit. Each bit is held for a programmable number of clocks, and the bit order is selectable per word. It converts register-bank words into a UART-style line for off-block links.

---
 rtl/usr_frame_serializer.sv | 112 +++++++++++
 tb/tb_usr_frame_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/usr_frame_serializer.sv
// usr_frame_serializer: valid/ready word to framed serial line (start, data, stop).
// Define USR_FRAME_PARITY_EN to insert an even-parity bit before the stop bit.
module usr_frame_serializer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);

`ifdef USR_FRAME_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bitc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic             lsb;
    logic             tick;

    assign tick      = cnt == CW'(CLKS_PER_BIT - 1);
    assign sh_nxt    = lsb ? sh >> 1 : sh << 1;
    assign din_ready = state == IDLE;
    assign busy      = state != IDLE;

    // sout is loaded with the level of the state being entered, so it changes with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bitc       <= '0;
            sh         <= '0;
            lsb        <= 1'b0;
            sout       <= 1'b1;
            frame_done <= 1'b0;
`ifdef USR_FRAME_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            cnt        <= tick ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    sout <= 1'b1;
                    if (din_valid) begin
                        sh    <= din;
                        lsb   <= lsb_first;
                        bitc  <= '0;
                        sout  <= 1'b0;
                        state <= START;
`ifdef USR_FRAME_PARITY_EN
                        par   <= ^din;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        sout  <= lsb ? sh[0] : sh[WIDTH-1];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitc == BW'(WIDTH - 1)) begin
`ifdef USR_FRAME_PARITY_EN
                            state <= PARITY;
                            sout  <= par;
`else
                            state <= STOP;
                            sout  <= 1'b1;
`endif
                        end else begin
                            bitc <= bitc + 1'b1;
                            sh   <= sh_nxt;
                            sout <= lsb ? sh_nxt[0] : sh_nxt[WIDTH-1];
                        end
                    end
                end
`ifdef USR_FRAME_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        sout  <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usr_frame_serializer.sv
// tb_usr_frame_serializer: random and directed frames against a bit-list reference model.
module tb_usr_frame_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din [2];
    logic       din_valid [2];
    logic       lsb_first [2];
    logic       din_ready [2];
    logic       sout [2];
    logic       busy [2];
    logic       frame_done [2];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    usr_frame_serializer #(.WIDTH(4), .CLKS_PER_BIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .lsb_first(lsb_first[0]), .sout(sout[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    usr_frame_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .lsb_first(lsb_first[1]), .sout(sout[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels, one entry per bit-time
    task automatic build(input logic [3:0] w, input logic lsb, output logic [6:0] bits, output int nb);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 4; i++) bits[1+i] = lsb ? w[i] : w[3-i];
        nb = 5;
`ifdef USR_FRAME_PARITY_EN
        bits[nb] = ^w;
        nb++;
`endif
        bits[nb] = 1'b1;
        nb++;
    endtask

    task automatic idle(input int u, input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_sout", 32'(sout[u]), 1);
            check("idle_busy", 32'(busy[u]), 0);
            check("idle_done", 32'(frame_done[u]), 0);
            check("idle_rdy", 32'(din_ready[u]), 1);
        end
    endtask

    // Called just after a negedge; returns at the negedge of the frame_done cycle
    task automatic send(input int u, input logic [3:0] w, input logic lsb,
                        input bit hold, input logic [3:0] nxt);
        logic [6:0] bits;
        int nb, cpb;
        cpb = (u == 0) ? 2 : 1;
        build(w, lsb, bits, nb);
        din[u] = w;
        lsb_first[u] = lsb;
        din_valid[u] = 1'b1;
        check("accept_rdy", 32'(din_ready[u]), 1);
        @(posedge clk);
        #1;
        din[u] = hold ? nxt : 4'($urandom);
        lsb_first[u] = 1'($urandom);
        din_valid[u] = hold;
        for (int c = 0; c < nb * cpb; c++) begin
            @(negedge clk);
            check("sout", 32'(sout[u]), 32'(bits[c / cpb]));
            check("busy", 32'(busy[u]), 1);
            check("rdy_busy", 32'(din_ready[u]), 0);
            check("done_early", 32'(frame_done[u]), 0);
        end
        @(negedge clk);
        check("done", 32'(frame_done[u]), 1);
        check("done_busy", 32'(busy[u]), 0);
        check("done_rdy", 32'(din_ready[u]), 1);
        check("done_sout", 32'(sout[u]), 1);
    endtask

    initial begin
        logic [6:0] bits;
        int nb;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            din_valid[i] = 1'b0;
            lsb_first[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_sout", 32'(sout[i]), 1);
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_done", 32'(frame_done[i]), 0);
            check("rst_rdy", 32'(din_ready[i]), 1);
        end
        rst_n = 1'b1;
        idle(0, 2);

        send(0, 4'b1011, 1'b0, 1'b0, 4'h0);
        idle(0, 1);
        send(0, 4'b1011, 1'b1, 1'b0, 4'h0);
        idle(0, 2);

        // back-to-back with valid held high
        send(0, 4'h5, 1'b0, 1'b1, 4'hA);
        send(0, 4'hA, 1'b0, 1'b0, 4'h0);
        idle(0, 1);

        // asynchronous reset during data bit 2
        build(4'b1011, 1'b0, bits, nb);
        din[0] = 4'b1011;
        lsb_first[0] = 1'b0;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1 din_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_sout", 32'(sout[0]), 32'(bits[3]));
        check("pre_rst_busy", 32'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sout", 32'(sout[0]), 1);
        check("mid_rst_busy", 32'(busy[0]), 0);
        check("mid_rst_rdy", 32'(din_ready[0]), 1);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_done", 32'(frame_done[0]), 0);
        end
        rst_n = 1'b1;
        idle(0, 3);
        send(0, 4'h3, 1'b0, 1'b0, 4'h0);
        idle(0, 1);

        // one clock per bit
        send(1, 4'hF, 1'b0, 1'b0, 4'h0);
        idle(1, 1);
        send(1, 4'b0110, 1'b1, 1'b1, 4'h9);
        send(1, 4'h9, 1'b0, 1'b0, 4'h0);

        for (int k = 0; k < 30; k++) begin
            int u;
            u = $urandom_range(0, 1);
            idle(u, $urandom_range(0, 2));
            send(u, 4'($urandom), 1'($urandom), 1'b0, 4'h0);
        end
        idle(0, 1);
        idle(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
